// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing path.
// - phase_t     : per-axis timing phase
// - DEF_*       : 640x480@60 default timing
// - vga_total() : line/frame length from the four region lengths
package vga_pkg;

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;
  localparam int DEF_CNT_W    = 10;

  function automatic int vga_total(input int active, input int front,
                                   input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): position counter plus phase FSM.
// Ports:
//   in_clk, reset : clock, synchronous active-high reset
//   step          : advance one position
//   cnt           : current position, 0..TOTAL-1
//   phase         : ACTIVE/FRONT/SYNC/BACK region of cnt
//   wrap          : cnt is at the last position (next step returns to 0)
module vga_axis_counter #(
  parameter int ACTIVE = 640,
  parameter int FRONT  = 16,
  parameter int SYNC   = 96,
  parameter int BACK   = 48,
  parameter int CNT_W  = 10
) (
  input  logic             in_clk,
  input  logic             reset,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output vga_pkg::phase_t  phase,
  output logic             wrap
);

  localparam int TOTAL = vga_pkg::vga_total(ACTIVE, FRONT, SYNC, BACK);

  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] FRONT_AT = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_AT  = CNT_W'(ACTIVE + FRONT);
  localparam logic [CNT_W-1:0] BACK_AT  = CNT_W'(ACTIVE + FRONT + SYNC);

  logic [CNT_W-1:0] cnt_nxt;
  vga_pkg::phase_t  phase_nxt;

  assign wrap = (cnt == LAST);

  always_ff @(posedge in_clk) begin
    if (reset) begin
      cnt   <= '0;
      phase <= vga_pkg::ACTIVE;
    end else begin
      cnt   <= cnt_nxt;
      phase <= phase_nxt;
    end
  end

  // Phase moves together with the count, keyed on the count being entered,
  // so phase always describes the position held in cnt.
  always_comb begin
    cnt_nxt   = cnt;
    phase_nxt = phase;
    if (step) begin
      if (wrap) begin
        cnt_nxt   = '0;
        phase_nxt = vga_pkg::ACTIVE;
      end else begin
        cnt_nxt = cnt + 1'b1;
        unique case (phase)
          vga_pkg::ACTIVE: if (cnt_nxt == FRONT_AT) phase_nxt = vga_pkg::FRONT;
          vga_pkg::FRONT:  if (cnt_nxt == SYNC_AT)  phase_nxt = vga_pkg::SYNC;
          vga_pkg::SYNC:   if (cnt_nxt == BACK_AT)  phase_nxt = vga_pkg::BACK;
          vga_pkg::BACK:   phase_nxt = vga_pkg::BACK;
          default:         phase_nxt = vga_pkg::ACTIVE;
        endcase
      end
    end
  end

endmodule

// File: rtl/vga_sync_generator.sv
// VGA timing generator: sync pulses, blanking, pixel coordinates and
// line/frame start pulses. Advances one pixel per in_clk cycle with pix_en.
// Ports:
//   in_clk, reset : system clock, synchronous active-high reset
//   pix_en        : pixel advance enable (re-timed divider tick)
//   hsync, vsync  : sync outputs, active level SYNC_POL
//   video_on      : inside both active regions
//   x, y          : pixel coordinate when video_on, else 0
//   line_start    : 1-cycle pulse after horizontal wrap
//   frame_start   : 1-cycle pulse after frame wrap
// All outputs are registered and lag the counters by one in_clk cycle.
module vga_sync_generator
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter bit SYNC_POL = 1'b0,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             in_clk,
  input  logic             reset,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  if (H_TOTAL > (1 << CNT_W)) begin : g_h_chk
    $fatal(1, "vga_sync_generator: H_TOTAL does not fit in CNT_W bits");
  end
  if (V_TOTAL > (1 << CNT_W)) begin : g_v_chk
    $fatal(1, "vga_sync_generator: V_TOTAL does not fit in CNT_W bits");
  end

  logic [CNT_W-1:0] h_cnt, v_cnt;
  phase_t           h_phase, v_phase;
  logic             h_wrap, v_wrap;
  logic             v_step;
  logic             on;

  // Vertical advances on the pixel that ends a line.
  assign v_step = pix_en & h_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .CNT_W(CNT_W)
  ) u_h (
    .in_clk(in_clk), .reset(reset), .step(pix_en),
    .cnt(h_cnt), .phase(h_phase), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .CNT_W(CNT_W)
  ) u_v (
    .in_clk(in_clk), .reset(reset), .step(v_step),
    .cnt(v_cnt), .phase(v_phase), .wrap(v_wrap)
  );

  assign on = (h_phase == ACTIVE) && (v_phase == ACTIVE);

  // Decode is resampled every cycle; with pix_en low the counters hold, so
  // the outputs settle and hold as well.
  always_ff @(posedge in_clk) begin
    if (reset) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= (h_phase == SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (v_phase == SYNC) ? SYNC_POL : ~SYNC_POL;
      video_on    <= on;
      x           <= on ? h_cnt : '0;
      y           <= on ? v_cnt : '0;
      line_start  <= v_step;
      frame_start <= v_step & v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_sync_generator.sv
module tb_vga_sync_generator;

  logic in_clk = 1'b0;
  logic reset;
  logic d_pix_en, s_pix_en;

  // default 640x480 instance
  logic       d_hsync, d_vsync, d_video_on, d_line_start, d_frame_start;
  logic [9:0] d_x, d_y;
  // small-timing instance: H 4/1/2/1, V 3/1/1/1
  logic       s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start;
  logic [3:0] s_x, s_y;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 in_clk = ~in_clk;

  vga_sync_generator u_dut (
    .in_clk(in_clk), .reset(reset), .pix_en(d_pix_en),
    .hsync(d_hsync), .vsync(d_vsync), .video_on(d_video_on),
    .x(d_x), .y(d_y), .line_start(d_line_start), .frame_start(d_frame_start)
  );

  vga_sync_generator #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_POL(1'b0), .CNT_W(4)
  ) u_small (
    .in_clk(in_clk), .reset(reset), .pix_en(s_pix_en),
    .hsync(s_hsync), .vsync(s_vsync), .video_on(s_video_on),
    .x(s_x), .y(s_y), .line_start(s_line_start), .frame_start(s_frame_start)
  );

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int hs_first, hs_last, hs_len, vs_first, vs_len, bad;
    logic [7:0] vo_pat, hs_pat;
    int ls_t[$];
    int fs_t[$];

    reset = 1'b1; d_pix_en = 1'b1; s_pix_en = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (300) tick();

    // ---- reset mid-frame, held 3 cycles with pix_en high
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_hsync", 32'(d_hsync), 1);
      check("rst_vsync", 32'(d_vsync), 1);
      check("rst_video_on", 32'(d_video_on), 0);
      check("rst_x", 32'(d_x), 0);
      check("rst_y", 32'(d_y), 0);
      check("rst_line_start", 32'(d_line_start), 0);
      check("rst_frame_start", 32'(d_frame_start), 0);
    end
    reset = 1'b0;
    tick();  // k = 1: decode of (0,0)
    check("rel_video_on", 32'(d_video_on), 1);
    check("rel_x", 32'(d_x), 0);
    check("rel_y", 32'(d_y), 0);
    check("rel_hsync", 32'(d_hsync), 1);
    check("rel_vsync", 32'(d_vsync), 1);
    check("rel_frame_start", 32'(d_frame_start), 0);

    // ---- full-rate horizontal timing; after tick k outputs show count k-1
    hs_first = 0; hs_last = 0; hs_len = 0;
    for (int k = 2; k <= 1601; k++) begin
      tick();
      if (!d_hsync && k <= 800) begin
        if (hs_first == 0) hs_first = k;
        hs_last = k;
        hs_len++;
      end
      if (d_line_start) ls_t.push_back(k);
      if (k == 101) begin
        check("x_at_100", 32'(d_x), 100);
        check("vo_at_100", 32'(d_video_on), 1);
      end
      if (k == 641) begin
        check("vo_at_640", 32'(d_video_on), 0);
        check("x_blank", 32'(d_x), 0);
      end
    end
    check("hsync_first_low", hs_first, 657);
    check("hsync_last_low", hs_last, 752);
    check("hsync_low_len", hs_len, 96);
    check("line_start_count", ls_t.size(), 2);
    if (ls_t.size() == 2) begin
      check("line_start_1", ls_t[0], 800);
      check("line_start_2", ls_t[1], 1600);
    end
    check("line2_x", 32'(d_x), 0);
    check("line2_y", 32'(d_y), 2);

    // ---- stall: counters reach h=5 on line 2, then pix_en drops
    repeat (4) tick();  // outputs x=4, counter h=5
    check("pre_stall_x", 32'(d_x), 4);
    d_pix_en = 1'b0;
    tick();
    check("stall_x", 32'(d_x), 5);
    check("stall_y", 32'(d_y), 2);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (d_x != 10'd5 || d_y != 10'd2 || !d_video_on || !d_hsync || !d_vsync ||
          d_line_start || d_frame_start) bad++;
    end
    check("stall_hold", bad, 0);
    d_pix_en = 1'b1;
    tick();
    check("resume_x0", 32'(d_x), 5);
    tick();
    check("resume_x1", 32'(d_x), 6);

    // ---- half-rate pix_en on default timing
    reset = 1'b1; d_pix_en = 1'b0;
    tick();
    reset = 1'b0;
    ls_t.delete();
    for (int k = 1; k <= 3300; k++) begin
      d_pix_en = k[0];
      tick();
      if (d_line_start) ls_t.push_back(k);
    end
    check("half_ls_count", ls_t.size(), 2);
    if (ls_t.size() == 2) begin
      check("half_ls_first", ls_t[0], 1599);
      check("half_ls_period", ls_t[1] - ls_t[0], 1600);
    end

    // ---- small timing, full rate
    reset = 1'b1; s_pix_en = 1'b1;
    tick();
    reset = 1'b0;
    vo_pat = '0; hs_pat = '0; vs_first = 0; vs_len = 0;
    ls_t.delete(); fs_t.delete();
    for (int k = 1; k <= 97; k++) begin
      tick();
      if (k <= 8) begin
        vo_pat = {vo_pat[6:0], s_video_on};
        hs_pat = {hs_pat[6:0], s_hsync};
      end
      if (!s_vsync && k <= 48) begin
        if (vs_first == 0) vs_first = k;
        vs_len++;
      end
      if (s_line_start) ls_t.push_back(k);
      if (s_frame_start) begin
        fs_t.push_back(k);
        check("fs_implies_ls", 32'(s_line_start), 1);
      end
      if (k == 3) check("small_x2", 32'(s_x), 2);
      if (k == 17) begin
        check("small_y2", 32'(s_y), 2);
        check("small_vo_y2", 32'(s_video_on), 1);
      end
      if (k == 25) begin
        check("small_vo_vfront", 32'(s_video_on), 0);
        check("small_y_blank", 32'(s_y), 0);
      end
      if (k == 49) begin
        check("wrap_next_fs", 32'(s_frame_start), 0);
        check("wrap_next_ls", 32'(s_line_start), 0);
        check("wrap_next_x", 32'(s_x), 0);
        check("wrap_next_y", 32'(s_y), 0);
        check("wrap_next_vo", 32'(s_video_on), 1);
      end
    end
    check("small_vo_pattern", 32'(vo_pat), 32'h0F0);
    check("small_hs_pattern", 32'(hs_pat), 32'h0F9);
    check("small_vs_first", vs_first, 33);
    check("small_vs_len", vs_len, 8);
    check("small_ls_count", ls_t.size(), 12);
    check("small_fs_count", fs_t.size(), 2);
    if (fs_t.size() == 2) begin
      check("small_fs_first", fs_t[0], 48);
      check("small_fs_period", fs_t[1] - fs_t[0], 48);
    end

    // ---- small timing, half rate
    reset = 1'b1; s_pix_en = 1'b0;
    tick();
    reset = 1'b0;
    fs_t.delete(); vs_len = 0;
    for (int k = 1; k <= 200; k++) begin
      s_pix_en = k[0];
      tick();
      if (!s_vsync && k <= 96) vs_len++;
      if (s_frame_start) fs_t.push_back(k);
    end
    check("half_small_vs_len", vs_len, 16);
    check("half_small_fs_count", fs_t.size(), 2);
    if (fs_t.size() == 2) begin
      check("half_small_fs_first", fs_t[0], 95);
      check("half_small_fs_period", fs_t[1] - fs_t[0], 96);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
